// File: rtl/adjust_cmd_scheduler.sv
// Command scheduler for the image-adjust datapath: arbitrates UART/key command bytes, queues legal
// commands, clamps steps against shadow counters and emits spaced, optionally frame-aligned strobes.
module adjust_cmd_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned FRAME_ALIGN = 1,
    parameter int unsigned BR_MIN      = 20,
    parameter int unsigned BR_MAX      = 230,
    parameter int unsigned HUE_MIN     = 50,
    parameter int unsigned HUE_MAX     = 150
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       uart_valid,
    input  logic [7:0] uart_byte,
    output logic       uart_ready,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    input  logic       frame_start,
    output logic       command_flag,
    output logic [3:0] ctrl_command_out,
    output logic [3:0] value_command_out,
    output logic [7:0] brightness_shadow,
    output logic [7:0] hue_shadow,
    output logic       gray_mode,
    output logic [7:0] drop_cnt,
    output logic       fifo_full,
    output logic       busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [7:0]  SHADOW_RST = 8'd100;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WAIT_FRAME, S_ISSUE, S_GAP
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            fifo_empty;
    logic [GW-1:0]   gap_cnt;
    logic            gap_done;
    logic            init_active;
    logic [1:0]      init_idx;
    logic            rr_uart;

    logic            can_accept, uart_take, key_take, acc_valid, acc_legal, push, pop;
    logic [7:0]      acc_byte, init_cmd, cmd, out_byte;
    logic            is_gray, is_br, is_rst, emit;
    logic [8:0]      sh9, lo9, hi9, step9, room9, clamped9;

    function automatic logic is_legal(input logic [7:0] b);
        return (b[7:1] == 7'h30) || (b[7:4] == 4'h7) || (b[7:4] == 4'h8);
    endfunction

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));

    // The pointer only moves on contention, so a lone source never starves the other.
    assign can_accept = !fifo_full && !init_active;
    assign uart_ready = can_accept && (!key_valid || rr_uart);
    assign key_ready  = can_accept && (!uart_valid || !rr_uart);
    assign uart_take  = uart_valid && uart_ready;
    assign key_take   = key_valid && key_ready;
    assign acc_valid  = uart_take || key_take;
    assign acc_byte   = uart_take ? uart_byte : key_byte;
    assign acc_legal  = is_legal(acc_byte);
    assign push       = acc_valid && acc_legal;
    assign pop        = (state == S_ISSUE) && !init_active;

    always_comb begin
        case (init_idx)
            2'd0:    init_cmd = 8'h70;
            2'd1:    init_cmd = 8'h80;
            default: init_cmd = 8'h60;
        endcase
    end

    always_comb begin
        cmd     = init_active ? init_cmd : fifo_mem[rd_ptr];
        is_gray = (cmd[7:4] == 4'h6);
        is_br   = (cmd[7:4] == 4'h7);
        is_rst  = (cmd[3:0] == 4'h0);
        sh9     = is_br ? {1'b0, brightness_shadow} : {1'b0, hue_shadow};
        lo9     = is_br ? 9'(BR_MIN) : 9'(HUE_MIN);
        hi9     = is_br ? 9'(BR_MAX) : 9'(HUE_MAX);
        step9   = {6'd0, cmd[2:0]};
        if (cmd[3]) room9 = (sh9 > lo9) ? (sh9 - lo9) : '0;
        else        room9 = (hi9 > sh9) ? (hi9 - sh9) : '0;
        clamped9 = (step9 < room9) ? step9 : room9;
        emit     = is_gray || is_rst || (clamped9 != '0);
        out_byte = (is_gray || is_rst) ? cmd : {cmd[7:3], clamped9[2:0]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:       state_nx = (FRAME_ALIGN != 0) ? S_WAIT_FRAME : S_ISSUE;
            S_IDLE:       if (!fifo_empty) state_nx = (FRAME_ALIGN != 0) ? S_WAIT_FRAME : S_ISSUE;
            S_WAIT_FRAME: if (frame_start) state_nx = S_ISSUE;
            S_ISSUE:      state_nx = S_GAP;
            S_GAP: begin
                if (gap_done) begin
                    // Init commands chain straight into the next issue without an IDLE cycle.
                    if (init_active && (init_idx != 2'd2))
                        state_nx = (FRAME_ALIGN != 0) ? S_WAIT_FRAME : S_ISSUE;
                    else
                        state_nx = S_IDLE;
                end
            end
            default:      state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= acc_byte;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state             <= S_INIT;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            gap_cnt           <= '0;
            init_active       <= 1'b1;
            init_idx          <= '0;
            rr_uart           <= 1'b1;
            command_flag      <= 1'b0;
            ctrl_command_out  <= '0;
            value_command_out <= '0;
            brightness_shadow <= SHADOW_RST;
            hue_shadow        <= SHADOW_RST;
            gray_mode         <= 1'b0;
            drop_cnt          <= '0;
        end else begin
            state <= state_nx;

            if (uart_valid && key_valid && acc_valid) rr_uart <= !uart_take;
            if (acc_valid && !acc_legal && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            if (state == S_ISSUE)    gap_cnt <= '0;
            else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;

            if ((state == S_GAP) && gap_done && init_active) begin
                if (init_idx == 2'd2) init_active <= 1'b0;
                else                  init_idx    <= init_idx + 2'd1;
            end

            command_flag <= 1'b0;
            if ((state == S_ISSUE) && emit) begin
                command_flag      <= 1'b1;
                ctrl_command_out  <= out_byte[7:4];
                value_command_out <= out_byte[3:0];
                if (is_gray) begin
                    gray_mode <= cmd[0];
                end else if (is_br) begin
                    if (is_rst)      brightness_shadow <= SHADOW_RST;
                    else if (cmd[3]) brightness_shadow <= brightness_shadow - clamped9[7:0];
                    else             brightness_shadow <= brightness_shadow + clamped9[7:0];
                end else begin
                    if (is_rst)      hue_shadow <= SHADOW_RST;
                    else if (cmd[3]) hue_shadow <= hue_shadow - clamped9[7:0];
                    else             hue_shadow <= hue_shadow + clamped9[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_adjust_cmd_scheduler.sv
// Directed bench: one unaligned instance for decode/clamp/latency/arbitration, one frame-aligned
// instance for the stall and per-frame issue behaviour.
module tb_adjust_cmd_scheduler;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       rst_n0, uart_valid0, uart_ready0, key_valid0, key_ready0, frame0, flag0;
    logic [7:0] uart_byte0, key_byte0, br0, hue0, drop0;
    logic [3:0] ctrl0, val0;
    logic       gray0, full0, busy0;

    logic       rst_n1, uart_valid1, uart_ready1, key_valid1, key_ready1, frame1, flag1;
    logic [7:0] uart_byte1, key_byte1, br1, hue1, drop1;
    logic [3:0] ctrl1, val1;
    logic       gray1, full1, busy1;

    adjust_cmd_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(16), .FRAME_ALIGN(0)) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n0),
        .uart_valid(uart_valid0), .uart_byte(uart_byte0), .uart_ready(uart_ready0),
        .key_valid(key_valid0), .key_byte(key_byte0), .key_ready(key_ready0),
        .frame_start(frame0), .command_flag(flag0),
        .ctrl_command_out(ctrl0), .value_command_out(val0),
        .brightness_shadow(br0), .hue_shadow(hue0), .gray_mode(gray0),
        .drop_cnt(drop0), .fifo_full(full0), .busy(busy0));

    adjust_cmd_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(16), .FRAME_ALIGN(1)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n1),
        .uart_valid(uart_valid1), .uart_byte(uart_byte1), .uart_ready(uart_ready1),
        .key_valid(key_valid1), .key_byte(key_byte1), .key_ready(key_ready1),
        .frame_start(frame1), .command_flag(flag1),
        .ctrl_command_out(ctrl1), .value_command_out(val1),
        .brightness_shadow(br1), .hue_shadow(hue1), .gray_mode(gray1),
        .drop_cnt(drop1), .fifo_full(full1), .busy(busy1));

    int          cyc = 0;
    logic [7:0]  log0 [$];
    int          cyc_log0 [$];
    logic [7:0]  log1 [$];
    int          passed = 0;
    int          total  = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (flag0) begin
            log0.push_back({ctrl0, val0});
            cyc_log0.push_back(cyc);
        end
        if (flag1) log1.push_back({ctrl1, val1});
    end

    typedef struct {
        logic [7:0] in_byte;
        bit         exp_strobe;
        logic [7:0] exp_out;
        int         exp_br;
        int         exp_hue;
        int         exp_gray;
        int         exp_drop;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    task automatic push(input int sel, input logic [7:0] b);
        bit   done = 0;
        logic rdy;
        @(negedge sys_clk);
        if (sel == 0) begin uart_valid0 = 1'b1; uart_byte0 = b; end
        else          begin uart_valid1 = 1'b1; uart_byte1 = b; end
        #1;
        for (int i = 0; i < 2000; i++) begin
            rdy = (sel == 0) ? uart_ready0 : uart_ready1;
            @(posedge sys_clk); #1;
            if (rdy) begin done = 1; break; end
        end
        uart_valid0 = 1'b0;
        uart_valid1 = 1'b0;
        check("push_accepted", int'(done), 1);
    endtask

    task automatic wait_idle(input int sel);
        logic b;
        for (int i = 0; i < 1000; i++) begin
            b = (sel == 0) ? busy0 : busy1;
            if (!b) break;
            @(posedge sys_clk); #1;
        end
        b = (sel == 0) ? busy0 : busy1;
        check("idle_reached", int'(b), 0);
    endtask

    task automatic pulse_frame1();
        @(negedge sys_clk); frame1 = 1'b1;
        @(negedge sys_clk); frame1 = 1'b0;
    endtask

    initial begin
        int n, c0, cnt;
        // {byte, strobe, out, brightness, hue, gray, drop} starting from br=103 hue=100
        vecs[0]  = '{8'h61, 1'b1, 8'h61, 103, 100, 1, 0};
        vecs[1]  = '{8'h60, 1'b1, 8'h60, 103, 100, 0, 0};
        vecs[2]  = '{8'h7A, 1'b1, 8'h7A, 101, 100, 0, 0};
        vecs[3]  = '{8'h85, 1'b1, 8'h85, 101, 105, 0, 0};
        vecs[4]  = '{8'h8F, 1'b1, 8'h8F, 101,  98, 0, 0};
        vecs[5]  = '{8'h80, 1'b1, 8'h80, 101, 100, 0, 0};
        vecs[6]  = '{8'h70, 1'b1, 8'h70, 100, 100, 0, 0};
        vecs[7]  = '{8'h55, 1'b0, 8'h00, 100, 100, 0, 1};
        vecs[8]  = '{8'hFF, 1'b0, 8'h00, 100, 100, 0, 2};
        vecs[9]  = '{8'h78, 1'b0, 8'h00, 100, 100, 0, 2};
        vecs[10] = '{8'h62, 1'b0, 8'h00, 100, 100, 0, 3};
        vecs[11] = '{8'h8F, 1'b1, 8'h8F, 100,  93, 0, 3};
        vecs[12] = '{8'h8F, 1'b1, 8'h8F, 100,  86, 0, 3};
        vecs[13] = '{8'h8F, 1'b1, 8'h8F, 100,  79, 0, 3};
        vecs[14] = '{8'h8F, 1'b1, 8'h8F, 100,  72, 0, 3};
        vecs[15] = '{8'h8F, 1'b1, 8'h8F, 100,  65, 0, 3};
        vecs[16] = '{8'h8F, 1'b1, 8'h8F, 100,  58, 0, 3};
        vecs[17] = '{8'h8F, 1'b1, 8'h8F, 100,  51, 0, 3};
        vecs[18] = '{8'h8F, 1'b1, 8'h89, 100,  50, 0, 3};
        vecs[19] = '{8'h89, 1'b0, 8'h00, 100,  50, 0, 3};

        rst_n0 = 0; rst_n1 = 0;
        uart_valid0 = 0; uart_byte0 = 0; key_valid0 = 0; key_byte0 = 0; frame0 = 0;
        uart_valid1 = 0; uart_byte1 = 0; key_valid1 = 0; key_byte1 = 0; frame1 = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_flag", flag0, 0);
        check("rst_br", br0, 100);
        check("rst_hue", hue0, 100);
        check("rst_gray", gray0, 0);
        check("rst_drop", drop0, 0);
        check("rst_full", full0, 0);
        check("rst_busy", busy0, 1);
        check("rst_ready", uart_ready0, 0);
        @(negedge sys_clk); rst_n0 = 1; rst_n1 = 1;

        // Init sequence, unaligned
        wait_idle(0);
        check("init_count", log0.size(), 3);
        if (log0.size() >= 3) begin
            check("init_cmd0", log0[0], 8'h70);
            check("init_cmd1", log0[1], 8'h80);
            check("init_cmd2", log0[2], 8'h60);
            check("init_space01", cyc_log0[1] - cyc_log0[0], 17);
            check("init_space12", cyc_log0[2] - cyc_log0[1], 17);
        end
        check("init_br", br0, 100);
        check("init_hue", hue0, 100);
        check("init_gray", gray0, 0);

        // Accept-to-strobe latency
        @(negedge sys_clk); uart_valid0 = 1; uart_byte0 = 8'h73; #1;
        check("lat_ready", uart_ready0, 1);
        @(posedge sys_clk); #1;
        uart_valid0 = 0;
        c0 = cyc;
        n = log0.size();
        wait_idle(0);
        check("lat_count", log0.size() - n, 1);
        if (log0.size() > n) begin
            check("lat_cycle", cyc_log0[n] - c0, 2);
            check("lat_out", log0[n], 8'h73);
        end
        check("lat_br", br0, 103);

        foreach (vecs[i]) begin
            n = log0.size();
            push(0, vecs[i].in_byte);
            wait_idle(0);
            check($sformatf("vec%0d_strobes", i), log0.size() - n, int'(vecs[i].exp_strobe));
            if (vecs[i].exp_strobe && log0.size() > n)
                check($sformatf("vec%0d_out", i), log0[n], vecs[i].exp_out);
            check($sformatf("vec%0d_br", i), br0, vecs[i].exp_br);
            check($sformatf("vec%0d_hue", i), hue0, vecs[i].exp_hue);
            check($sformatf("vec%0d_gray", i), gray0, vecs[i].exp_gray);
            check($sformatf("vec%0d_drop", i), drop0, vecs[i].exp_drop);
        end

        // Brightness upper clamp: 100 + 18*7 + 2 = 228
        for (int i = 0; i < 18; i++) push(0, 8'h77);
        push(0, 8'h72);
        wait_idle(0);
        check("climb_br", br0, 228);
        n = log0.size();
        push(0, 8'h77);
        wait_idle(0);
        check("clamp_count", log0.size() - n, 1);
        if (log0.size() > n) check("clamp_out", log0[n], 8'h72);
        check("clamp_br", br0, 230);
        n = log0.size();
        push(0, 8'h71);
        wait_idle(0);
        check("clamp0_count", log0.size() - n, 0);
        check("clamp0_br", br0, 230);
        check("clamp0_drop", drop0, 3);

        // Contended arbitration
        n = log0.size();
        @(negedge sys_clk);
        uart_valid0 = 1; uart_byte0 = 8'h81; key_valid0 = 1; key_byte0 = 8'h89;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("arb%0d_grant", k), uart_ready0 ? 1 : (key_ready0 ? 2 : 0), (k % 2 == 0) ? 1 : 2);
            @(posedge sys_clk);
        end
        #1; uart_valid0 = 0; key_valid0 = 0;
        wait_idle(0);
        check("arb_count", log0.size() - n, 4);
        if (log0.size() >= n + 4) begin
            check("arb_out0", log0[n],   8'h81);
            check("arb_out1", log0[n+1], 8'h89);
            check("arb_out2", log0[n+2], 8'h81);
            check("arb_out3", log0[n+3], 8'h89);
        end
        check("arb_hue", hue0, 50);

        // drop_cnt saturation
        n = log0.size();
        @(negedge sys_clk); uart_valid0 = 1; uart_byte0 = 8'hFF;
        repeat (300) @(posedge sys_clk);
        #1; uart_valid0 = 0;
        @(posedge sys_clk); #1;
        check("sat_drop", drop0, 255);
        check("sat_strobes", log0.size() - n, 0);

        // Reset mid-GAP with a queued entry
        n = log0.size();
        push(0, 8'h7B);
        push(0, 8'h7B);
        for (int i = 0; i < 100 && log0.size() == n; i++) begin
            @(posedge sys_clk); #1;
        end
        check("pre_rst_strobe", log0.size() - n, 1);
        @(negedge sys_clk); rst_n0 = 0;
        @(posedge sys_clk); #1;
        check("mid_rst_flag", flag0, 0);
        check("mid_rst_drop", drop0, 0);
        check("mid_rst_br", br0, 100);
        check("mid_rst_hue", hue0, 100);
        check("mid_rst_full", full0, 0);
        check("mid_rst_ready", uart_ready0, 0);
        @(negedge sys_clk); rst_n0 = 1;
        n = log0.size();
        wait_idle(0);
        repeat (5) @(posedge sys_clk);
        #1;
        check("rerun_count", log0.size() - n, 3);
        if (log0.size() >= n + 3) begin
            check("rerun_cmd0", log0[n],   8'h70);
            check("rerun_cmd1", log0[n+1], 8'h80);
            check("rerun_cmd2", log0[n+2], 8'h60);
        end

        // Frame-aligned instance
        check("fa_no_frame", log1.size(), 0);
        for (int k = 0; k < 3; k++) begin
            pulse_frame1();
            repeat (30) @(posedge sys_clk);
            #1;
            check($sformatf("fa_init%0d_count", k), log1.size(), k + 1);
        end
        if (log1.size() >= 3) begin
            check("fa_init_cmd0", log1[0], 8'h70);
            check("fa_init_cmd1", log1[1], 8'h80);
            check("fa_init_cmd2", log1[2], 8'h60);
        end
        for (int k = 0; k < 4; k++) push(1, 8'h81 + 8'(k));
        check("fa_full", full1, 1);
        @(negedge sys_clk); uart_valid1 = 1; uart_byte1 = 8'h85;
        cnt = 0;
        repeat (10) begin
            #1; if (uart_ready1) cnt++;
            @(negedge sys_clk);
        end
        check("fa_stall_ready", cnt, 0);
        check("fa_stall_strobes", log1.size(), 3);
        frame1 = 1; #1;
        check("fa_ready_f0", uart_ready1, 0);
        @(negedge sys_clk); frame1 = 0; #1;
        check("fa_ready_f1", uart_ready1, 0);
        @(negedge sys_clk); #1;
        check("fa_ready_f2", uart_ready1, 1);
        @(posedge sys_clk); #1;
        uart_valid1 = 0;
        check("fa_first_pop", log1.size(), 4);
        check("fa_refull", full1, 1);
        for (int k = 1; k <= 4; k++) begin
            repeat (25) @(posedge sys_clk);
            #1;
            check($sformatf("fa_hold%0d", k), log1.size(), 3 + k);
            pulse_frame1();
            repeat (5) @(posedge sys_clk);
            #1;
            check($sformatf("fa_issue%0d", k), log1.size(), 4 + k);
        end
        if (log1.size() >= 8)
            for (int k = 0; k < 5; k++)
                check($sformatf("fa_out%0d", k), log1[3+k], 8'h81 + 8'(k));
        wait_idle(1);
        check("fa_hue", hue1, 115);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
